mem_guard: RTL

MEM_GUARD -- requirements
Module: mem_guard

---
 rtl/mem_guard.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_guard.sv
// mem_guard: per-thread region protection checker for fetch and data requests with a host-transfer FSM.
// Ports: clk, rst (async, active-high); fetch i_rd/i_addr/i_trd -> i_chk_vld/i_segfault;
// data d_rd/d_wr/d_addr/d_trd -> d_chk_vld/d_segfault/d_busy; host mem_op/mem_addr, ready/tx_done;
// CSR csr_wr/csr_addr/csr_wdata -> csr_rdata (region r at 4r+0/1/2, fault status 0xF0).
// Option MEM_GUARD_FAULT_ADDR_EN: first-fault address capture per thread at 0xE0+t.
module mem_guard #(
  parameter int NUM_TRD = 8,
  parameter int NUM_RGN = 4,
  parameter int ADDR_W  = 32,
  localparam int TRD_W  = $clog2(NUM_TRD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [TRD_W-1:0]  i_trd,
  output logic              i_chk_vld,
  output logic              i_segfault,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [TRD_W-1:0]  d_trd,
  output logic              d_chk_vld,
  output logic              d_segfault,
  output logic              d_busy,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              ready,
  input  logic              tx_done,
  input  logic              csr_wr,
  input  logic [7:0]        csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_base  [NUM_RGN];
  logic [ADDR_W-1:0]   r_limit [NUM_RGN];
  logic [2:0]          r_perm  [NUM_RGN];
  logic [7:0]          r_mask  [NUM_RGN];
  logic [NUM_TRD-1:0]  r_fault;
  logic                r_i_vld, r_i_seg, r_d_vld, r_d_seg;
  logic [1:0]          r_mem_op;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                w_i_ok, w_d_ok, w_d_req, w_i_flt, w_d_flt;
  logic [NUM_TRD-1:0]  w_set, w_clr;
`ifdef MEM_GUARD_FAULT_ADDR_EN
  logic [ADDR_W-1:0]   r_fa [NUM_TRD];
`endif
  // Overlapping regions OR together; a write needs W, a read R, a fetch X.
  always_comb begin
    w_i_ok = 1'b0;
    w_d_ok = 1'b0;
    for (int r = 0; r < NUM_RGN; r++) begin
      w_i_ok = w_i_ok | (i_addr >= r_base[r] && i_addr <= r_limit[r] && r_mask[r][i_trd] && r_perm[r][0]);
      w_d_ok = w_d_ok | (d_addr >= r_base[r] && d_addr <= r_limit[r] && r_mask[r][d_trd] &&
                         (d_wr ? r_perm[r][2] : r_perm[r][1]));
    end
  end
  // Data requests arriving while a transfer is in flight are dropped unchecked.
  assign w_d_req = (d_rd | d_wr) & (r_state == S_IDLE);
  assign w_i_flt = i_rd & ~w_i_ok;
  assign w_d_flt = w_d_req & ~w_d_ok;
  assign w_clr   = (csr_wr && csr_addr == 8'hF0) ? csr_wdata[NUM_TRD-1:0] : '0;
  always_comb begin
    w_set = '0;
    if (w_i_flt) w_set[i_trd] = 1'b1;
    if (w_d_flt) w_set[d_trd] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_op   <= 2'b00;
      r_mem_addr <= '0;
      r_i_vld    <= 1'b0;
      r_i_seg    <= 1'b0;
      r_d_vld    <= 1'b0;
      r_d_seg    <= 1'b0;
    end else begin
      r_i_vld <= i_rd;
      r_i_seg <= w_i_flt;
      r_d_vld <= w_d_req;
      r_d_seg <= w_d_flt;
      case (r_state)
        S_IDLE: if (w_d_req && w_d_ok) begin
          r_state    <= S_REQ;
          r_mem_op   <= d_wr ? 2'b11 : 2'b01;
          r_mem_addr <= d_addr;
        end
        S_REQ: if (ready) begin
          r_state  <= S_WAIT;
          r_mem_op <= 2'b00;
        end
        S_WAIT: if (tx_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_RGN; r++) begin
        r_base[r]  <= '0;
        r_limit[r] <= '0;
        r_perm[r]  <= 3'b000;
        r_mask[r]  <= 8'h00;
      end
      r_base[0]  <= ADDR_W'(32'h0001_0000);
      r_limit[0] <= ADDR_W'(32'h0001_01FF);
      r_perm[0]  <= 3'b001;
      r_mask[0]  <= 8'hFF;
      r_base[1]  <= ADDR_W'(32'h0001_0200);
      r_limit[1] <= ADDR_W'(32'h0001_02FF);
      r_perm[1]  <= 3'b110;
      r_mask[1]  <= 8'hFF;
      r_fault    <= '0;
    end else begin
      for (int r = 0; r < NUM_RGN; r++) begin
        if (csr_wr && csr_addr == 8'(4*r))   r_base[r]  <= csr_wdata[ADDR_W-1:0];
        if (csr_wr && csr_addr == 8'(4*r+1)) r_limit[r] <= csr_wdata[ADDR_W-1:0];
        if (csr_wr && csr_addr == 8'(4*r+2)) begin
          r_perm[r] <= csr_wdata[2:0];
          r_mask[r] <= csr_wdata[15:8];
        end
      end
      r_fault <= (r_fault & ~w_clr) | w_set;
    end
  end
`ifdef MEM_GUARD_FAULT_ADDR_EN
  // Capture only while the status bit is clear; a same-thread fetch fault takes priority over a data fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TRD; t++) r_fa[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_TRD; t++)
        if (!r_fault[t]) begin
          if (w_i_flt && i_trd == TRD_W'(t)) r_fa[t] <= i_addr;
          else if (w_d_flt && d_trd == TRD_W'(t)) r_fa[t] <= d_addr;
        end
    end
  end
`endif
  always_comb begin
    csr_rdata = '0;
    for (int r = 0; r < NUM_RGN; r++) begin
      if (csr_addr == 8'(4*r))   csr_rdata = 32'(r_base[r]);
      if (csr_addr == 8'(4*r+1)) csr_rdata = 32'(r_limit[r]);
      if (csr_addr == 8'(4*r+2)) csr_rdata = 32'({r_mask[r], 5'b00000, r_perm[r]});
    end
    if (csr_addr == 8'hF0) csr_rdata = 32'(r_fault);
`ifdef MEM_GUARD_FAULT_ADDR_EN
    for (int t = 0; t < NUM_TRD; t++)
      if (csr_addr == 8'(224+t)) csr_rdata = 32'(r_fa[t]);
`endif
  end
  assign i_chk_vld  = r_i_vld;
  assign i_segfault = r_i_seg;
  assign d_chk_vld  = r_d_vld;
  assign d_segfault = r_d_seg;
  assign d_busy     = (r_state != S_IDLE);
  assign mem_op     = r_mem_op;
  assign mem_addr   = r_mem_addr;
endmodule
